// File: rtl/game_sequencer.sv
// Game sequencer: board selection, move strobes and timers for a 2x2 sliding puzzle.
// Every button acts on its rising edge only. A won board freezes its counters until confirm.
module game_sequencer #(
  parameter int INIT_CYCLES = 4,
  parameter int TICK_DIV    = 1000
) (
  input  logic        clk_d,
  input  logic        reset,
  input  logic [3:0]  btn_dir,
  input  logic        btn_next,
  input  logic        btn_confirm,
  input  logic        btn_restart,
  input  logic        win_flag,
  output logic [1:0]  game_status,
  output logic [11:0] origin_board,
  output logic [3:0]  act,
  output logic        active,
  output logic        restart,
  output logic [9:0]  move_count,
  output logic [9:0]  seconds
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [9:0]    CNT_MAX   = 10'd999;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAME_INITIAL = 2'b10,
    GAMING       = 2'b01,
    WINNED       = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    dir_prev_q;
  logic          next_prev_q, conf_prev_q, rst_prev_q, win_q;
  logic [1:0]    hist_q;
  logic [3:0]    act_q, act_d;
  logic          active_q, active_d, restart_q, restart_d;
  logic [9:0]    moves_q, moves_d, secs_q, secs_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] init_q, init_d;

  logic [3:0] dir_e, dir_sel;
  logic       next_e, conf_e, rst_e, settled, quiet;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  assign dir_e   = btn_dir & ~dir_prev_q;
  assign next_e  = btn_next & ~next_prev_q;
  assign conf_e  = btn_confirm & ~conf_prev_q;
  assign rst_e   = btn_restart & ~rst_prev_q;
  // Two's-complement trick isolates the lowest set edge bit.
  assign dir_sel = dir_e & (~dir_e + 4'd1);
  // hist_q holds the strobe from one and two cycles ago.
  assign settled = ~active_q & ~hist_q[0];
  assign quiet   = settled & ~hist_q[1];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    act_d     = act_q;
    active_d  = 1'b0;
    restart_d = 1'b0;
    moves_d   = moves_q;
    secs_d    = secs_q;
    tick_d    = tick_q;
    init_d    = init_q;
    case (state_q)
      CHOSE_BOARD: begin
        if (conf_e) begin
          state_d = GAME_INITIAL;
          init_d  = '0;
          moves_d = '0;
          secs_d  = '0;
          tick_d  = '0;
        end else if (next_e) begin
          idx_d = idx_q + 2'd1;
        end
      end
      GAME_INITIAL: begin
        if (init_q == INIT_LAST) state_d = GAMING;
        else                     init_d  = init_q + IW'(1);
      end
      GAMING: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          secs_d = sat_inc(secs_q);
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (conf_e) begin
          state_d = CHOSE_BOARD;
        end else if (rst_e) begin
          restart_d = 1'b1;
          moves_d   = '0;
          secs_d    = '0;
        end else if (win_flag && win_q && quiet) begin
          state_d = WINNED;
        end else if ((dir_e != 4'd0) && settled) begin
          act_d    = dir_sel;
          active_d = 1'b1;
          moves_d  = sat_inc(moves_q);
        end
      end
      WINNED: begin
        if (conf_e) state_d = CHOSE_BOARD;
      end
      default: state_d = CHOSE_BOARD;
    endcase
  end

  // NOTE: reset is synchronous; edge registers load the live levels so a held button never fires on release of reset.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      state_q   <= CHOSE_BOARD;
      idx_q     <= '0;
      act_q     <= '0;
      active_q  <= 1'b0;
      restart_q <= 1'b0;
      moves_q   <= '0;
      secs_q    <= '0;
      tick_q    <= '0;
      init_q    <= '0;
      hist_q    <= '0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      active_q  <= active_d;
      restart_q <= restart_d;
      moves_q   <= moves_d;
      secs_q    <= secs_d;
      tick_q    <= tick_d;
      init_q    <= init_d;
      hist_q    <= {hist_q[0], active_q};
      win_q     <= win_flag;
    end
    dir_prev_q  <= btn_dir;
    next_prev_q <= btn_next;
    conf_prev_q <= btn_confirm;
    rst_prev_q  <= btn_restart;
  end

  always_comb begin
    case (idx_q)
      2'd0:    origin_board = 12'b001_000_100_011;
      2'd1:    origin_board = 12'b011_010_100_000;
      2'd2:    origin_board = 12'b010_011_100_001;
      default: origin_board = 12'b000_011_100_010;
    endcase
  end

  assign game_status = state_q;
  assign act         = act_q;
  assign active      = active_q;
  assign restart     = restart_q;
  assign move_count  = moves_q;
  assign seconds     = secs_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter INIT_CYCLES, default 4: number of cycles spent in GAME_INITIAL.
REQ-002 Parameter TICK_DIV, default 1000: clk_d cycles per timer second.
REQ-003 clk_d  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_dir  input  4  direction buttons, level, pre-synchronised; [0]=up [1]=right [2]=down [3]=left.
REQ-006 btn_next  input  1  board-select step button, level.
REQ-007 btn_confirm  input  1  confirm/abort button, level.
REQ-008 btn_restart  input  1  restart-current-board button, level.
REQ-009 win_flag  input  1  solved indication from the puzzle datapath, one cycle behind its board.
REQ-010 game_status  output  2  00 CHOSE_BOARD, 10 GAME_INITIAL, 01 GAMING, 11 WINNED.
REQ-011 origin_board  output  12  selected start board, {LU,RU,LD,RD} 3 bits each, 100 = blank.
REQ-012 act  output  4  one-hot move request, same bit map as btn_dir.
REQ-013 active  output  1  one-cycle strobe qualifying act.
REQ-014 restart  output  1  one-cycle strobe resetting the datapath board.
REQ-015 move_count  output  10  moves made this game.
REQ-016 seconds  output  10  elapsed play seconds.

Function
REQ-017 All buttons SHALL be acted on only on rising edge (registered previous level vs current); held levels SHALL produce no repeats.
REQ-018 Board ROM SHALL be index 0: 001_000_100_011, 1: 011_010_100_000, 2: 010_011_100_001, 3: 000_011_100_010; origin_board = ROM[board_idx], combinational from board_idx register.
REQ-019 CHOSE_BOARD: btn_next edge SHALL increment board_idx mod 4 (3 -> 0); btn_confirm edge SHALL move to GAME_INITIAL next cycle; both edges same cycle: confirm wins, board_idx unchanged.
REQ-020 GAME_INITIAL: SHALL clear move_count, seconds, tick divider on entry and remain exactly INIT_CYCLES cycles, then enter GAMING; all buttons ignored.
REQ-021 GAMING: a btn_dir rising edge SHALL set act to that single bit and pulse active for exactly one cycle, one cycle after the edge; act SHALL hold its last value otherwise.
REQ-022 Multiple btn_dir edges same cycle: lowest index SHALL win, others discarded.
REQ-023 After an active strobe, further btn_dir edges SHALL be ignored for 2 cycles (datapath settle).
REQ-024 move_count SHALL increment on each active strobe and saturate at 999.
REQ-025 Tick divider SHALL count 0..TICK_DIV-1 in GAMING only; on wrap seconds SHALL increment, saturating at 999.
REQ-026 win_flag SHALL be honoured only when high 2 consecutive cycles while in GAMING and no active strobe in the last 3 cycles; then state -> WINNED.
REQ-027 btn_restart edge in GAMING SHALL pulse restart for one cycle, clear move_count and seconds, stay in GAMING; ignored in other states.
REQ-028 btn_confirm edge in GAMING SHALL abort to CHOSE_BOARD (board_idx kept); simultaneous restart+confirm: confirm wins, no restart pulse.
REQ-029 Simultaneous btn_dir and btn_restart edges: restart wins, no active strobe.
REQ-030 WINNED: move_count and seconds frozen; btn_confirm edge -> CHOSE_BOARD; other buttons ignored.
REQ-031 active and restart SHALL be 0 in every state other than GAMING.

Reset
REQ-032 On reset: game_status=00, board_idx=0, act=0000, active=0, restart=0, move_count=0, seconds=0, tick divider=0, edge registers loaded with current button levels (no spurious edge on release).
REQ-033 Reset mid-game SHALL take effect next edge regardless of state, overriding all button events.

Verification
REQ-034 Reset; 5 btn_next edges -> board_idx=1, origin_board=011_010_100_000; confirm -> 10 for 4 cycles, then 01, counters 0.
REQ-035 GAMING; btn_dir=0110 rising together -> act=0010, active one cycle; held 20 cycles -> no further strobe; move_count=1.
REQ-036 GAMING, TICK_DIV=4, run 4000 cycles -> seconds saturates 999; 1000 move edges -> move_count=999.
REQ-037 GAMING; win_flag high 1 cycle -> stays 01; high 2 cycles, no recent move -> 11; counters frozen; confirm -> 00.
REQ-038 GAMING; restart+dir same cycle -> restart one cycle, no active, counters 0; restart+confirm -> 00, no restart pulse.
REQ-039 Reset asserted in WINNED with btn_confirm edge -> 00, board_idx=0, all outputs at reset values.
